bcd_to_bin_seq: RTL

Sequential BCD-to-binary converter. It consumes a packed 4-digit BCD value, in the same format the BCD counters drive on `q[15:0]`, and returns the equivalent unsigned binary number. It processes one digit per clock, most significant digit first, with a start/busy/done handshake. It sits downstream of the BCD counter family wherever a count must be compared, scaled or logged in binary.

---
 rtl/bcd_to_bin_seq.sv | 121 ++++++++++++
 1 files changed

// File: rtl/bcd_to_bin_seq.sv
// Sequential packed-BCD to binary converter: one digit per clock, MSD first,
// with a start/busy/done handshake and registered outputs.
module bcd_to_bin_seq #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd,
    output logic                  busy,
    output logic                  done,
    output logic [BIN_W-1:0]      bin,
    output logic                  err
);

    // state | meaning
    // IDLE  | waiting for start; also the cycle in which done pulses
    // CONV  | folding one digit per cycle into acc, MSD first
    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t             state, state_nx;
    logic [BCD_W-1:0]   dig_sr, dig_sr_nx;
    logic [BIN_W-1:0]   acc, acc_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic               invalid, invalid_nx;
    logic               busy_nx, done_nx, err_nx;
    logic [BIN_W-1:0]   bin_nx;

    logic [3:0]         top_digit;
    logic [BIN_W-1:0]   acc_step;
    logic               bcd_bad;
    logic               last_digit;

    always_comb begin
        bcd_bad = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd[4*k +: 4] > 4'd9) begin
                bcd_bad = 1'b1;
            end
        end
    end

    // acc*10 + digit as shift-add; truncation to BIN_W is intentional
    assign top_digit  = dig_sr[BCD_W-1 -: 4];
    assign acc_step   = (acc << 3) + (acc << 1) + BIN_W'(top_digit);
    assign last_digit = (cnt == CNT_W'(DIGITS - 1));

    always_comb begin
        state_nx   = state;
        dig_sr_nx  = dig_sr;
        acc_nx     = acc;
        cnt_nx     = cnt;
        invalid_nx = invalid;
        busy_nx    = busy;
        done_nx    = 1'b0;
        bin_nx     = bin;
        err_nx     = err;

        case (state)
            IDLE: begin
                if (start) begin
                    dig_sr_nx  = bcd;
                    acc_nx     = '0;
                    cnt_nx     = '0;
                    invalid_nx = bcd_bad;
                    busy_nx    = 1'b1;
                    state_nx   = CONV;
                end
            end
            CONV: begin
                acc_nx    = acc_step;
                dig_sr_nx = dig_sr << 4;
                cnt_nx    = cnt + 1'b1;
                if (last_digit) begin
                    // bad digits still accumulate; only the published result is zeroed
                    bin_nx   = invalid ? '0 : acc_step;
                    err_nx   = invalid;
                    done_nx  = 1'b1;
                    busy_nx  = 1'b0;
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
                busy_nx  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            dig_sr  <= '0;
            acc     <= '0;
            cnt     <= '0;
            invalid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            bin     <= '0;
            err     <= 1'b0;
        end else begin
            state   <= state_nx;
            dig_sr  <= dig_sr_nx;
            acc     <= acc_nx;
            cnt     <= cnt_nx;
            invalid <= invalid_nx;
            busy    <= busy_nx;
            done    <= done_nx;
            bin     <= bin_nx;
            err     <= err_nx;
        end
    end

endmodule
